// File: rtl/axis_traffic_gen.sv
// rtl/axis_traffic_gen.sv - synthetic AXI-Stream packet source for router injection ports
module axis_traffic_gen #(
    parameter int TDATA_WIDTH       = 128,
    parameter int TID_WIDTH         = 2,
    parameter int TDEST_WIDTH       = 4,
    parameter int NOC_NUM_ENDPOINTS = 16,
    parameter int MAX_PKT_LEN       = 16,
    parameter int LEN_WIDTH         = $clog2(MAX_PKT_LEN + 1),
    parameter int CNT_WIDTH         = 32
) (
    input  logic                   clk_usr,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [TDEST_WIDTH-1:0] src_address,
    input  logic [LEN_WIDTH-1:0]   pkt_len,
    input  logic [CNT_WIDTH-1:0]   num_pkts,
    input  logic [7:0]             gap_cycles,
    input  logic                   dest_mode,
    input  logic [TDEST_WIDTH-1:0] fixed_dest,
    input  logic [TID_WIDTH-1:0]   tid,
    output logic                   axis_tvalid,
    input  logic                   axis_tready,
    output logic [TDATA_WIDTH-1:0] axis_tdata,
    output logic                   axis_tlast,
    output logic [TID_WIDTH-1:0]   axis_tid,
    output logic [TDEST_WIDTH-1:0] axis_tdest,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_WIDTH-1:0]   pkts_sent,
    output logic [CNT_WIDTH-1:0]   flits_sent
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [LEN_WIDTH-1:0]   LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]   LEN_MAX  = LEN_WIDTH'(MAX_PKT_LEN);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [TDEST_WIDTH-1:0] DEST_ONE = TDEST_WIDTH'(1);
    localparam logic [TDEST_WIDTH-1:0] LAST_EP  = TDEST_WIDTH'(NOC_NUM_ENDPOINTS - 1);
    localparam logic [7:0]             GAP_ONE  = 8'd1;

    logic [1:0]             state_q,     state_d;
    logic                   stop_flag_q, stop_flag_d;
    logic [LEN_WIDTH-1:0]   len_q,       len_d;
    logic [CNT_WIDTH-1:0]   num_q,       num_d;
    logic [7:0]             gap_len_q,   gap_len_d;
    logic [7:0]             gap_cnt_q,   gap_cnt_d;
    logic                   mode_q,      mode_d;
    logic [TDEST_WIDTH-1:0] fixed_q,     fixed_d;
    logic [TDEST_WIDTH-1:0] src_q,       src_d;
    logic [TID_WIDTH-1:0]   tid_q,       tid_d;
    logic [LEN_WIDTH-1:0]   idx_q,       idx_d;
    logic [TDEST_WIDTH-1:0] dest_q,      dest_d;
    logic [CNT_WIDTH-1:0]   pkts_q,      pkts_d;
    logic [CNT_WIDTH-1:0]   flits_q,     flits_d;

    logic [LEN_WIDTH-1:0]   len_norm;
    logic                   handshake;
    logic                   is_last;
    logic                   stop_req;
    logic                   run_complete;

    // Next endpoint address, wrapping at the endpoint count
    function automatic logic [TDEST_WIDTH-1:0] rr_inc(input logic [TDEST_WIDTH-1:0] a);
        if (a >= LAST_EP) begin
            return '0;
        end
        return a + DEST_ONE;
    endfunction

    // Next round-robin destination, never targeting our own endpoint
    function automatic logic [TDEST_WIDTH-1:0] rr_next(input logic [TDEST_WIDTH-1:0] cur,
                                                       input logic [TDEST_WIDTH-1:0] own);
        logic [TDEST_WIDTH-1:0] n;
        n = rr_inc(cur);
        if (n == own) begin
            n = rr_inc(n);
        end
        return n;
    endfunction

    // Clamp requested packet length into 1..MAX_PKT_LEN
    always_comb begin
        len_norm = pkt_len;
        if (pkt_len == '0) begin
            len_norm = LEN_ONE;
        end else if (pkt_len > LEN_MAX) begin
            len_norm = LEN_MAX;
        end
    end

    assign handshake    = (state_q == ST_SEND) && axis_tready;
    assign is_last      = (idx_q == (len_q - LEN_ONE));
    assign stop_req     = stop_flag_q | stop;
    assign run_complete = (num_q != '0) && ((pkts_q + CNT_ONE) == num_q);

    // Generator state machine: config latch, flit stepping, gap timing, stop handling
    always_comb begin
        state_d     = state_q;
        stop_flag_d = stop_flag_q;
        len_d       = len_q;
        num_d       = num_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        mode_d      = mode_q;
        fixed_d     = fixed_q;
        src_d       = src_q;
        tid_d       = tid_q;
        idx_d       = idx_q;
        dest_d      = dest_q;
        pkts_d      = pkts_q;
        flits_d     = flits_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    len_d       = len_norm;
                    num_d       = num_pkts;
                    gap_len_d   = gap_cycles;
                    gap_cnt_d   = '0;
                    mode_d      = dest_mode;
                    fixed_d     = fixed_dest;
                    src_d       = src_address;
                    tid_d       = tid;
                    idx_d       = '0;
                    dest_d      = dest_mode ? rr_inc(src_address) : fixed_dest;
                    pkts_d      = '0;
                    flits_d     = '0;
                    stop_flag_d = 1'b0;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND: begin
                if (stop) begin
                    stop_flag_d = 1'b1;
                end
                if (handshake) begin
                    flits_d = flits_q + CNT_ONE;
                    if (is_last) begin
                        pkts_d = pkts_q + CNT_ONE;
                        idx_d  = '0;
                        if (stop_req || run_complete) begin
                            state_d = ST_DONE;
                        end else begin
                            // Destination only moves between packets
                            dest_d = mode_q ? rr_next(dest_q, src_q) : fixed_q;
                            if (gap_len_q != '0) begin
                                gap_cnt_d = gap_len_q;
                                state_d   = ST_GAP;
                            end
                        end
                    end else begin
                        idx_d = idx_q + LEN_ONE;
                    end
                end
            end

            ST_GAP: begin
                if (stop) begin
                    stop_flag_d = 1'b1;
                end
                if (stop_req) begin
                    state_d = ST_DONE;
                end else if (gap_cnt_q <= GAP_ONE) begin
                    gap_cnt_d = '0;
                    state_d   = ST_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_usr) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stop_flag_q <= 1'b0;
            len_q       <= '0;
            num_q       <= '0;
            gap_len_q   <= '0;
            gap_cnt_q   <= '0;
            mode_q      <= 1'b0;
            fixed_q     <= '0;
            src_q       <= '0;
            tid_q       <= '0;
            idx_q       <= '0;
            dest_q      <= '0;
            pkts_q      <= '0;
            flits_q     <= '0;
        end else begin
            state_q     <= state_d;
            stop_flag_q <= stop_flag_d;
            len_q       <= len_d;
            num_q       <= num_d;
            gap_len_q   <= gap_len_d;
            gap_cnt_q   <= gap_cnt_d;
            mode_q      <= mode_d;
            fixed_q     <= fixed_d;
            src_q       <= src_d;
            tid_q       <= tid_d;
            idx_q       <= idx_d;
            dest_q      <= dest_d;
            pkts_q      <= pkts_d;
            flits_q     <= flits_d;
        end
    end

    // Flit payload: sequence number, flit index, source address; upper bits zero.
    // Every field comes from registers that only change at a handshake, so the
    // payload holds steady while the sink stalls.
    always_comb begin
        axis_tdata                        = '0;
        axis_tdata[31:0]                  = 32'(pkts_q);
        axis_tdata[47:32]                 = 16'(idx_q);
        axis_tdata[48 +: TDEST_WIDTH]     = src_q;
    end

    assign axis_tvalid = (state_q == ST_SEND);
    assign axis_tlast  = (state_q == ST_SEND) && is_last;
    assign axis_tid    = tid_q;
    assign axis_tdest  = dest_q;
    assign busy        = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign done        = (state_q == ST_DONE);
    assign pkts_sent   = pkts_q;
    assign flits_sent  = flits_q;

endmodule

// File: doc/axis_traffic_gen.md
Name: axis_traffic_gen

Overview:
Synthetic AXI-Stream packet source that drives the injection port (axis_in_*) of one router wrap in the NoC parameter-sweep fabric. Runs in the user clock domain. It emits configurable multi-flit packets to a fixed or round-robin destination, with optional inter-packet gaps. It exposes packet and flit counters so sweep benches can measure throughput and check delivery.

Parameters:
TDATA_WIDTH, 128, payload width; must be >= 52
TID_WIDTH, 2, width of axis_tid
TDEST_WIDTH, 4, width of axis_tdest and of the endpoint address
NOC_NUM_ENDPOINTS, 16, number of endpoints; round-robin wraps at this value
MAX_PKT_LEN, 16, maximum flits per packet
LEN_WIDTH, $clog2(MAX_PKT_LEN+1), width of pkt_len
CNT_WIDTH, 32, width of the packet and flit counters and of num_pkts

Ports:
clk_usr  in  1  user clock; the only clock
rst_n  in  1  reset; synchronous, active-low
start  in  1  one-cycle pulse; latches the config inputs and begins generation (honoured only in IDLE or DONE)
stop  in  1  pulse; sticky request to finish at the next packet boundary
src_address  in  TDEST_WIDTH  this endpoint's address
pkt_len  in  LEN_WIDTH  flits per packet; 0 is treated as 1; values > MAX_PKT_LEN saturate to MAX_PKT_LEN
num_pkts  in  CNT_WIDTH  packets to send; 0 means run until stop
gap_cycles  in  8  idle cycles inserted after each packet
dest_mode  in  1  0 = fixed_dest, 1 = round-robin
fixed_dest  in  TDEST_WIDTH  destination when dest_mode=0
tid  in  TID_WIDTH  value driven on axis_tid
axis_tvalid  out  1  AXIS valid
axis_tready  in  1  AXIS ready
axis_tdata  out  TDATA_WIDTH  flit payload
axis_tlast  out  1  last flit of packet
axis_tid  out  TID_WIDTH  latched tid
axis_tdest  out  TDEST_WIDTH  current packet destination
busy  out  1  high in SEND or GAP
done  out  1  high in DONE
pkts_sent  out  CNT_WIDTH  packets completed since the last start
flits_sent  out  CNT_WIDTH  flits accepted since the last start

Behaviour:
- Reset (rst_n=0 at a clk_usr edge):
  - State goes to IDLE.
  - All outputs and counters go to 0; the sticky stop flag clears.
- States and transitions:
  - IDLE: on start, latch the config, clear the counters, go to SEND. Drive axis_tvalid on the next cycle (1-cycle start latency).
  - SEND: axis_tvalid=1. A handshake is tvalid&tready.
    - On a non-last handshake, flit_idx increments.
    - On the last handshake (flit_idx==len-1, axis_tlast=1): pkts_sent++, flit_idx=0, then:
      - DONE if stop_flag, or if num_pkts!=0 and pkts_sent+1==num_pkts;
      - else GAP if gap_cycles!=0;
      - else stay in SEND with the next packet's tvalid held high (back-to-back, no bubble).
  - GAP: down-counts gap_cycles (exactly gap_cycles cycles with tvalid=0), then SEND. If stop_flag is set, go to DONE immediately.
  - DONE: done=1, tvalid=0, counters held. A start here behaves as in IDLE.
- stop:
  - Sets stop_flag in any state except IDLE/DONE.
  - Never truncates a packet.
  - stop in the same cycle as a last-flit handshake ends the run after that packet.
- AXIS rule: once tvalid rises, tdata/tlast/tdest/tid stay stable until the handshake. flits_sent increments on every handshake.
- Payload:
  - tdata[31:0] = packet sequence number (= pkts_sent at packet start).
  - tdata[47:32] = flit_idx.
  - tdata[51:48+] = src_address (TDEST_WIDTH bits starting at bit 48).
  - All remaining bits = 0.
- Destination:
  - Mode 0: fixed_dest.
  - Mode 1: the first dest is (src_address+1) mod NOC_NUM_ENDPOINTS. Each later packet takes the next address mod NOC_NUM_ENDPOINTS, skipping src_address.
  - tdest changes only between packets.
- Counters wrap modulo 2^CNT_WIDTH; no saturation.
- start outside IDLE/DONE is ignored; config inputs are sampled only at an accepted start.
- Reset mid-packet: the packet is abandoned and tvalid drops the next cycle. The downstream router is reset by the same rst_n.

Test Plan:
- src=5, pkt_len=4, num_pkts=3, gap=0, mode 0, fixed_dest=9, tready=1 -> 12 consecutive flits starting 1 cycle after start; tlast on flits 4/8/12; tdest=9; tdata[31:0]=0,1,2; pkts_sent=3; flits_sent=12; done=1.
- Same config, tready toggling 1,0,1,0 -> tdata/tlast/tdest stable while tvalid&!tready; identical flit sequence; done after 12 handshakes.
- mode 1, src=15, N=16, pkt_len=1, num_pkts=17 -> dests 0,1,…,14,0,1; 15 never driven.
- pkt_len=3, gap=5, num_pkts=2 -> exactly 5 cycles with tvalid=0 between flit 3 and flit 4.
- num_pkts=0, pkt_len=8, stop pulsed during flit 3 of packet 2 -> packet 2 completes all 8 flits, then DONE; pkts_sent=2 (packets 1 and 2, seq 0 and 1).
- rst_n=0 during flit 2 while tready=0 -> tvalid=0 and all counters=0 from the next edge; a new start restarts at seq 0.
